// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage load/store unit sitting directly in front of the MEM/WB
// register. A decoded memory operation from EX/MEM is turned into a single
// req/ack transaction on the data-memory port. The pipeline is stalled while
// the access is outstanding. The formatted load result is then presented for
// exactly one cycle (RESP) with stall released, so MEM/WB can capture it.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_valid            : EX/MEM holds a valid instruction
//   mem_read, mem_write : load / store (both set is handled as a load)
//   funct3              : RV32I size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU;
//                         remaining codes are handled as word accesses)
//   addr                : byte address
//   store_data          : rs2 value for stores
//   read_data           : sign/zero-extended load data (valid in RESP)
//   stall               : freeze upstream pipeline registers and MEM/WB
//   bus_error           : one-cycle pulse in RESP after a timed-out access
//   dmem_*              : word-aligned data-memory request port
//   misaligned          : (MISALIGN_TRAP_EN only) pulse in RESP for a trapped
//                         misaligned access
//
// Parameters
//   ADDR_WIDTH     : byte address width
//   TIMEOUT_CYCLES : WAIT cycles allowed before the access is abandoned
//                    (1..65535)
//
// Build option
//   MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses issue
//                      no memory request and go straight to RESP with the
//                      misaligned output pulsed. When undefined, halfwords
//                      use addr[1] only and words ignore addr[1:0].
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic [31:0]           read_data,
    output logic                  stall,
    output logic                  bus_error,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                  misaligned
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic access;
    logic is_load;
    logic is_store;
    logic size_b;
    logic size_h;
    logic size_w;
    logic misalign_hit;

    assign access   = in_valid & (mem_read | mem_write);
    assign is_load  = mem_read;
    assign is_store = mem_write & ~mem_read;

    // funct3[1:0]: 00 byte, 01 half, 1x word. This also folds the undefined
    // codes 011/110/111 into word accesses.
    assign size_b = (funct3[1:0] == 2'b00);
    assign size_h = (funct3[1:0] == 2'b01);
    assign size_w = funct3[1];

`ifdef MISALIGN_TRAP_EN
    assign misalign_hit = (size_h & addr[0]) | (size_w & (addr[1:0] != 2'b00));
`else
    assign misalign_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    logic [7:0]  rd_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_fmt;
    logic [31:0] load_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rd_lane[addr[1:0]];
    assign sel_half = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_fmt = dmem_rdata;
        if (size_b) begin
            // funct3[2] = 1 selects the unsigned variant.
            load_fmt = funct3[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        end else if (size_h) begin
            load_fmt = funct3[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
        end
    end

    // Stores capture zero so read_data is 0 in their RESP cycle.
    assign load_word = is_load ? load_fmt : 32'd0;

    // ------------------------------------------------------------------
    // Store lane alignment
    // ------------------------------------------------------------------
    logic [3:0]  wstrb_raw;
    logic [31:0] wdata_raw;

    always_comb begin
        wstrb_raw = 4'b1111;
        wdata_raw = store_data;
        if (size_b) begin
            wstrb_raw = 4'b0001 << addr[1:0];
            wdata_raw = {4{store_data[7:0]}};
        end else if (size_h) begin
            wstrb_raw = addr[1] ? 4'b1100 : 4'b0011;
            wdata_raw = {2{store_data[15:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        err_q;
    logic        err_d;
`ifdef MISALIGN_TRAP_EN
    logic        mis_q;
    logic        mis_d;
`endif
    logic        req_c;
    logic        stall_c;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        req_c   = 1'b0;
        stall_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
                    if (misalign_hit) begin
                        // Trapped: no bus traffic, one stall cycle, then RESP.
                        state_d = ST_RESP;
                        data_d  = 32'd0;
`ifdef MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end else begin
                        req_c   = 1'b1;
                        count_d = 16'd0;
                        if (dmem_ack) begin
                            state_d = ST_RESP;
                            data_d  = load_word;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end

            ST_WAIT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_ack) begin
                    state_d = ST_RESP;
                    data_d  = load_word;
                end else if (count_q == TIMEOUT_LAST) begin
                    // This is the TIMEOUT_CYCLES-th WAIT cycle without ack.
                    state_d = ST_RESP;
                    data_d  = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end

            ST_RESP: begin
                // Always back to IDLE: the instruction still presented this
                // cycle has completed and must not be issued again.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= 16'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset overrides the handshake combinationally so an access
    // in flight is dropped in the very cycle reset is seen.
    // ------------------------------------------------------------------
    assign dmem_req   = req_c & ~reset;
    assign stall      = stall_c & ~reset;
    assign bus_error  = err_q & ~reset;
    assign read_data  = ((state_q == ST_RESP) && !reset) ? data_q : 32'd0;

    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = dmem_req ? {addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem_wstrb = dmem_we ? wstrb_raw : 4'd0;
    assign dmem_wdata = dmem_we ? wdata_raw : 32'd0;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = mis_q & ~reset;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] read_data;
    logic        stall;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .read_data  (read_data),
        .stall      (stall),
        .bus_error  (bus_error),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
`ifdef MISALIGN_TRAP_EN
        ,
        .misaligned (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        in_valid   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    // One memory instruction with ack after ack_after WAIT cycles
    // (0 = ack in the request cycle, negative = never).
    task automatic run_wait(input string nm, input logic [2:0] f3, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] sd, input int ack_after,
                            input logic [31:0] rdata, input logic [31:0] e_addr, input logic e_we,
                            input logic [3:0] e_strb, input logic [31:0] e_wdata, input int e_nstall,
                            input logic [31:0] e_rd, input logic e_err);
        int  n_stall;
        bit  done;
        n_stall = 0;
        done    = 1'b0;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        dmem_rdata = rdata;
        dmem_ack   = (ack_after == 0);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                n_stall++;
                check({nm, " req"},   32'(dmem_req),   32'h1);
                check({nm, " addr"},  dmem_addr,       e_addr);
                check({nm, " we"},    32'(dmem_we),    32'(e_we));
                check({nm, " wstrb"}, 32'(dmem_wstrb), 32'(e_strb));
                check({nm, " wdata"}, dmem_wdata,      e_wdata);
                @(posedge clk); #1;
                dmem_ack = (cyc + 1 == ack_after);
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s stall_bound: stall still high after 40 cycles, required release", nm);
        end
        // RESP cycle, instruction still presented
        check({nm, " stall_cycles"}, 32'(n_stall),   32'(e_nstall));
        check({nm, " read_data"},    read_data,      e_rd);
        check({nm, " bus_error"},    32'(bus_error), 32'(e_err));
        check({nm, " resp_req"},     32'(dmem_req),  32'h0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check({nm, " post_bus_error"}, 32'(bus_error), 32'h0);
        check({nm, " post_read_data"}, read_data,      32'h0);
        $display("txn %s: stall_cycles=%0d read_data=0x%08h", nm, n_stall, e_rd);
    endtask

    typedef struct {
        logic        v;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic        e_stall;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        //                v     rd    wr    f3      addr       store_data     rdata          req   we    stall dmem_addr  wdata          strb     read_data
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'b0000, 32'h00000080};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'b0000, 32'hFFFF80FF};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'b0000, 32'h00001234};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h80FF1234, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'b0000, 32'h00000012};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00008001, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        4'b0000, 32'hFFFF8001};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h201, 32'h123456A5, 32'h0,        1'b1, 1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b0010, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h9999ABCD, 32'h0,        1'b1, 1'b1, 1'b1, 32'h200, 32'hABCDABCD, 4'b1100, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h204, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h204, 32'h12345678, 4'b1111, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 32'h010, 32'h0,        4'b0000, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 3'b100, 32'h302, 32'h55555555, 32'h00AB0000, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0,        4'b0000, 32'h000000AB};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        4'b0000, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        4'b0000, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h203, 32'h0000003C, 32'h0,        1'b1, 1'b1, 1'b1, 32'h200, 32'h3C3C3C3C, 4'b1000, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h200, 32'h0000BEEF, 32'h0,        1'b1, 1'b1, 1'b1, 32'h200, 32'hBEEFBEEF, 4'b0011, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 3'b111, 32'h208, 32'hA1B2C3D4, 32'h0,        1'b1, 1'b1, 1'b1, 32'h208, 32'hA1B2C3D4, 4'b1111, 32'h0};

        // ---------------- reset ----------------
        set_idle();
        reset    = 1'b1;
        in_valid = 1'b1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_override",   32'(dmem_req),  32'h0);
        check("rst_stall_override", 32'(stall),     32'h0);
        check("rst_bus_error",      32'(bus_error), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
        @(negedge clk);
        check("rst_read_data", read_data,        32'h0);
        check("rst_stall",     32'(stall),       32'h0);
        check("rst_req",       32'(dmem_req),    32'h0);
        check("rst_we",        32'(dmem_we),     32'h0);
        check("rst_wstrb",     32'(dmem_wstrb),  32'h0);
        check("rst_addr",      dmem_addr,        32'h0);
        check("rst_wdata",     dmem_wdata,       32'h0);
        $display("txn reset: outputs idle");

        // ---------------- single-cycle-ack vectors ----------------
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            in_valid   = vecs[i].v;
            mem_read   = vecs[i].rd;
            mem_write  = vecs[i].wr;
            funct3     = vecs[i].f3;
            addr       = vecs[i].a;
            store_data = vecs[i].sd;
            dmem_rdata = vecs[i].rdata;
            dmem_ack   = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d req", i),   32'(dmem_req),   32'(vecs[i].e_req));
            check($sformatf("v%0d we", i),    32'(dmem_we),    32'(vecs[i].e_we));
            check($sformatf("v%0d stall", i), 32'(stall),      32'(vecs[i].e_stall));
            check($sformatf("v%0d addr", i),  dmem_addr,       vecs[i].e_addr);
            check($sformatf("v%0d wdata", i), dmem_wdata,      vecs[i].e_wdata);
            check($sformatf("v%0d wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].e_strb));
            @(posedge clk); #1;
            set_idle();
            @(negedge clk);
            check($sformatf("v%0d read_data", i),  read_data,      vecs[i].e_rd);
            check($sformatf("v%0d resp_stall", i), 32'(stall),     32'h0);
            check($sformatf("v%0d bus_error", i),  32'(bus_error), 32'h0);
            $display("txn v%0d: f3=%03b addr=0x%08h read_data=0x%08h", i, vecs[i].f3, vecs[i].a, read_data);
        end

        // ---------------- multi-cycle sequences ----------------
        run_wait("lb_wait3",  3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 3, 32'h80FF1234,
                 32'h100, 1'b0, 4'b0000, 32'h0, 4, 32'hFFFFFF80, 1'b0);
        run_wait("lbu_wait3", 3'b100, 1'b1, 1'b0, 32'h103, 32'h0, 3, 32'h80FF1234,
                 32'h100, 1'b0, 4'b0000, 32'h0, 4, 32'h00000080, 1'b0);
        run_wait("sh_wait1",  3'b001, 1'b0, 1'b1, 32'h202, 32'h0000ABCD, 1, 32'h0,
                 32'h200, 1'b1, 4'b1100, 32'hABCDABCD, 2, 32'h0, 1'b0);
        run_wait("lw_timeout", 3'b010, 1'b1, 1'b0, 32'h100, 32'h0, -1, 32'h12345678,
                 32'h100, 1'b0, 4'b0000, 32'h0, 5, 32'h0, 1'b0 | 1'b1);
        // A plain access still works after a timeout.
        run_wait("lw_after_to", 3'b010, 1'b1, 1'b0, 32'h104, 32'h0, 2, 32'h0BADF00D,
                 32'h104, 1'b0, 4'b0000, 32'h0, 3, 32'h0BADF00D, 1'b0);

        // Reset during the second WAIT cycle; a late ack must be ignored.
        @(posedge clk); #1;
        in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
        dmem_rdata = 32'h55555555; dmem_ack = 1'b0;
        @(negedge clk);
        check("rstmid idle_req", 32'(dmem_req), 32'h1);
        @(posedge clk); #1;              // WAIT 1
        @(posedge clk); #1;              // WAIT 2
        reset = 1'b1;
        @(negedge clk);
        check("rstmid req",       32'(dmem_req),  32'h0);
        check("rstmid stall",     32'(stall),     32'h0);
        check("rstmid bus_error", 32'(bus_error), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0; mem_read = 1'b0;
        dmem_ack = 1'b1;
        @(negedge clk);
        check("rstmid late_ack_req",   32'(dmem_req), 32'h0);
        check("rstmid late_ack_stall", 32'(stall),    32'h0);
        check("rstmid late_ack_rd",    read_data,     32'h0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("rstmid after_rd",    read_data,  32'h0);
        check("rstmid after_stall", 32'(stall), 32'h0);
        $display("txn reset_mid_access: dropped, read_data=0x%08h", read_data);

`ifdef MISALIGN_TRAP_EN
        // Misaligned word: trapped without a bus request.
        @(posedge clk); #1;
        in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h101;
        dmem_rdata = 32'hFFFFFFFF; dmem_ack = 1'b1;
        @(negedge clk);
        check("mis req",   32'(dmem_req),   32'h0);
        check("mis stall", 32'(stall),      32'h1);
        check("mis early", 32'(misaligned), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis pulse",      32'(misaligned), 32'h1);
        check("mis read_data",  read_data,       32'h0);
        check("mis resp_stall", 32'(stall),      32'h0);
        check("mis resp_req",   32'(dmem_req),   32'h0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("mis pulse_end", 32'(misaligned), 32'h0);
        $display("txn misaligned_lw: trapped");
`else
        // Without trapping, a misaligned word just ignores addr[1:0].
        run_wait("lw_unaligned", 3'b010, 1'b1, 1'b0, 32'h101, 32'h0, 0, 32'h11223344,
                 32'h100, 1'b0, 4'b0000, 32'h0, 1, 32'h11223344, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
